ssp_rx_fifo: RTL and testbench
==============================

Name: ssp_rx_fifo

Overview:
- Parametrised successor to the lab SSP receive logic: TI synchronous-serial-frame receiver in the PCLK domain, with configurable frame width and bit order, back-to-back frame support, framing-error detection and a receive FIFO with valid/ready output.
- SSPCLKIN, SSPFSSIN and SSPRXD are asynchronous. They are synchronised and edge-detected inside the block; there is no separate SSPCLKIN clock domain.
- Sits between the SSP pins and the bus-side register interface.

Parameters:
- DATA_W, 8, frame width in bits; legal 4..16.
- FIFO_DEPTH, 8, receive FIFO entries; power of 2, at least 2.
- MSB_FIRST, 1, 1 = first serial bit lands in RxDATA[DATA_W-1]; 0 = first bit lands in RxDATA[0].

Ports:
- PCLK  in  1  system clock, rising edge.
- CLEAR  in  1  reset, synchronous, active-high.
- ENABLE  in  1  receiver enable.
- SSPCLKIN  in  1  serial bit clock, async; frequency at most PCLK/4.
- SSPFSSIN  in  1  frame sync, async; high for one bit period before the first bit of a frame.
- SSPRXD  in  1  serial data, async.
- RxREADY  in  1  consumer accepts head word.
- OVR_CLR  in  1  one-cycle pulse; clears OVERRUN.
- RxDATA  out  DATA_W  FIFO head word.
- RxVALID  out  1  FIFO non-empty.
- FIFO_LEVEL  out  clog2(FIFO_DEPTH)+1  occupied entries.
- OVERRUN  out  1  sticky; a completed word was dropped because the FIFO was full.
- FRAME_ERR  out  1  one-cycle pulse; frame aborted by early SSPFSSIN.

Behaviour:
- Reset (CLEAR=1 at a PCLK edge):
  - state=IDLE, bit counter=0, shift register=0, synchronisers=0.
  - FIFO emptied, pointers=0.
  - RxDATA=0, RxVALID=0, FIFO_LEVEL=0, OVERRUN=0, FRAME_ERR=0.
  - Reset mid-frame discards the partial word.
- Input path:
  - Each input passes through a 2-flop synchroniser; SSPCLKIN has an extra delay flop.
  - pe = sync2 & ~delay. pe is the sample strobe; SSPFSSIN and SSPRXD are taken from their sync2 in the pe cycle.
- FSM, evaluated only in pe cycles:
  - IDLE: FSS=1 -> SHIFT, cnt=0. Otherwise stay in IDLE.
  - SHIFT, cnt < DATA_W-1, FSS=0: shift in RXD, cnt++.
  - SHIFT, cnt < DATA_W-1, FSS=1, cnt > 0: FRAME_ERR pulse; partial word discarded; remain in SHIFT with cnt=0, treating the event as a new frame start; the RXD on this edge is not stored.
  - SHIFT, cnt = 0, FSS=1: not an error; the frame start is re-armed.
  - SHIFT, cnt = DATA_W-1: shift in the final bit and push the completed word.
    - FSS=1 on this edge: back-to-back frame; stay in SHIFT with cnt=0.
    - FSS=0 on this edge: go to IDLE.
- Bit order:
  - MSB_FIRST=1: shift left, new bit enters at LSB.
  - MSB_FIRST=0: shift right, new bit enters at MSB.
  - After DATA_W bits, the register holds the word in the specified orientation.
- ENABLE=0: FSM forced to IDLE, cnt=0, partial word discarded, no pushes. The FIFO keeps its contents and can still be popped.
- Latency:
  - Raw SSPCLKIN rise first captured at PCLK edge k gives pe in the cycle after edge k+1.
  - The push registers at edge k+2.
  - RxVALID/RxDATA are valid immediately after edge k+2 when the FIFO was empty (first-word fall-through).
- FIFO:
  - Pop occurs when RxVALID & RxREADY at a PCLK edge.
  - RxDATA always shows the head word; it holds its last value when the FIFO is empty.
  - Push + pop in the same cycle: both occur, and FIFO_LEVEL is unchanged.
  - Full and push without pop: word dropped, OVERRUN set, FIFO contents intact.
  - Full with simultaneous push and pop: push accepted, no overrun.
  - RxREADY while empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- OVERRUN: cleared by OVR_CLR. If OVR_CLR coincides with a new overrun, the set wins.
- FRAME_ERR: high for exactly one PCLK cycle per abort.

Test Plan:
- DATA_W=8, MSB_FIRST=1: FSS pulse, then serial 1,0,1,1,0,0,1,0 -> one push, RxDATA=8'hB2, RxVALID high at edge k+2 after the last SSPCLKIN rise, FIFO_LEVEL=1.
- Same bitstream with MSB_FIRST=0 -> RxDATA=8'h4D.
- Three back-to-back frames 8'h01, 8'h80, 8'hFF, with FSS high on each frame's last bit and RxREADY=0 -> FIFO_LEVEL=3; popping three times returns 01, 80, FF in order, then RxVALID=0.
- FSS asserted on bit 4 of a frame, followed by 8 bits of 8'h5A -> one FRAME_ERR pulse, no push of the partial word, next word is 8'h5A.
- FIFO_DEPTH=8, 9 frames with RxREADY=0 -> FIFO_LEVEL=8, OVERRUN=1, head word is frame 1. An OVR_CLR pulse clears OVERRUN. A 10th frame arriving in the same cycle as a pop is accepted without overrun.
- CLEAR=1 after 5 bits received and 2 words stored -> all outputs at reset values next cycle; a following full frame 8'h3C yields RxDATA=8'h3C, FIFO_LEVEL=1.

Source files
------------

// File: rtl/ssp_rx_fifo.sv
// TI synchronous-serial receiver with frame checking and
// a first-word-fall-through receive FIFO, all in PCLK.
module ssp_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int MSB_FIRST  = 1
) (
  input  logic                          PCLK,
  input  logic                          CLEAR,
  input  logic                          ENABLE,
  input  logic                          SSPCLKIN,
  input  logic                          SSPFSSIN,
  input  logic                          SSPRXD,
  input  logic                          RxREADY,
  input  logic                          OVR_CLR,
  output logic [DATA_W-1:0]             RxDATA,
  output logic                          RxVALID,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          OVERRUN,
  output logic                          FRAME_ERR
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  localparam logic [AW:0]   FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [1:0]        clk_s_q;
  logic [1:0]        fss_s_q;
  logic [1:0]        rxd_s_q;
  logic              clk_dly_q;
  logic              pe;
  logic              fss;
  logic              rxd;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d, sh_in;
  logic              ferr_q, ferr_d;
  logic              push;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       lvl_q;
  logic              ovr_q;
  logic [DATA_W-1:0] last_q;
  logic              pop;
  logic              full;
  logic              wr_en;

  // Two-flop synchronisers, plus a delay flop for edge detect
  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      clk_s_q   <= '0;
      fss_s_q   <= '0;
      rxd_s_q   <= '0;
      clk_dly_q <= 1'b0;
    end else begin
      clk_s_q   <= {clk_s_q[0], SSPCLKIN};
      fss_s_q   <= {fss_s_q[0], SSPFSSIN};
      rxd_s_q   <= {rxd_s_q[0], SSPRXD};
      clk_dly_q <= clk_s_q[1];
    end
  end

  assign pe  = clk_s_q[1] & ~clk_dly_q;
  assign fss = fss_s_q[1];
  assign rxd = rxd_s_q[1];

  // Word as it would look after taking the current bit
  always_comb begin
    sh_in = '0;
    if (MSB_FIRST != 0) sh_in = {sh_q[DATA_W-2:0], rxd};
    else                sh_in = {rxd, sh_q[DATA_W-1:1]};
  end

  // FSM state register
  always_ff @(posedge PCLK) begin
    if (CLEAR) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state, advanced only on SSPCLKIN rising edges
  always_comb begin
    state_d = state_q;
    if (!ENABLE) begin
      state_d = IDLE;
    end else if (pe) begin
      unique case (state_q)
        IDLE:  if (fss) state_d = SHIFT;
        SHIFT: if (cnt_q == LAST && !fss) state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: bit counter, shifter, push and abort strobes
  always_comb begin
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    push   = 1'b0;
    ferr_d = 1'b0;
    if (!ENABLE) begin
      cnt_d = '0;
      sh_d  = '0;
    end else if (pe) begin
      unique case (state_q)
        IDLE: begin
          if (fss) begin
            cnt_d = '0;
            sh_d  = '0;
          end
        end
        SHIFT: begin
          if (cnt_q == LAST) begin
            push  = 1'b1;
            cnt_d = '0;
            sh_d  = '0;
          end else if (fss) begin
            ferr_d = (cnt_q != '0);
            cnt_d  = '0;
            sh_d   = '0;
          end else begin
            sh_d  = sh_in;
            cnt_d = cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  // Receive datapath registers
  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      cnt_q  <= '0;
      sh_q   <= '0;
      ferr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      ferr_q <= ferr_d;
    end
  end

  assign pop   = RxVALID & RxREADY;
  assign full  = (lvl_q == FULL);
  assign wr_en = push & (~full | pop);

  // FIFO storage; contents need no reset
  always_ff @(posedge PCLK) begin
    if (wr_en) mem[wr_q] <= sh_in;
  end

  // FIFO pointers, level, sticky overrun and last-popped word
  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      wr_q   <= '0;
      rd_q   <= '0;
      lvl_q  <= '0;
      ovr_q  <= 1'b0;
      last_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + AW'(1);
      if (pop) begin
        rd_q   <= rd_q + AW'(1);
        last_q <= mem[rd_q];
      end
      if (wr_en && !pop)      lvl_q <= lvl_q + (AW + 1)'(1);
      else if (!wr_en && pop) lvl_q <= lvl_q - (AW + 1)'(1);
      if (push && full && !pop) ovr_q <= 1'b1;
      else if (OVR_CLR)         ovr_q <= 1'b0;
    end
  end

  assign RxVALID    = (lvl_q != '0);
  assign RxDATA     = RxVALID ? mem[rd_q] : last_q;
  assign FIFO_LEVEL = lvl_q;
  assign OVERRUN    = ovr_q;
  assign FRAME_ERR  = ferr_q;

endmodule

// File: tb/tb_ssp_rx_fifo.sv
// Bench for ssp_rx_fifo: both bit orders driven from one
// serial stream and compared against a queue model.
module tb_ssp_rx_fifo;

  localparam int W = 8;
  localparam int D = 8;

  logic PCLK = 1'b0;
  logic CLEAR, ENABLE, SCLK, FSS, RXD, RDY, OCLR;
  logic [W-1:0] dm, dl;
  logic vm, vl, om, ol, fm, fl;
  logic [3:0] lm, ll;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] last_w;
  bit ovr;
  int ferr_m = 0;
  int ferr_l = 0;
  int ferr_exp = 0;

  ssp_rx_fifo #(.DATA_W(W), .FIFO_DEPTH(D), .MSB_FIRST(1)) u_msb (
    .PCLK(PCLK), .CLEAR(CLEAR), .ENABLE(ENABLE),
    .SSPCLKIN(SCLK), .SSPFSSIN(FSS), .SSPRXD(RXD),
    .RxREADY(RDY), .OVR_CLR(OCLR),
    .RxDATA(dm), .RxVALID(vm), .FIFO_LEVEL(lm),
    .OVERRUN(om), .FRAME_ERR(fm)
  );

  ssp_rx_fifo #(.DATA_W(W), .FIFO_DEPTH(D), .MSB_FIRST(0)) u_lsb (
    .PCLK(PCLK), .CLEAR(CLEAR), .ENABLE(ENABLE),
    .SSPCLKIN(SCLK), .SSPFSSIN(FSS), .SSPRXD(RXD),
    .RxREADY(RDY), .OVR_CLR(OCLR),
    .RxDATA(dl), .RxVALID(vl), .FIFO_LEVEL(ll),
    .OVERRUN(ol), .FRAME_ERR(fl)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) begin
    if (fm === 1'b1) ferr_m++;
    if (fl === 1'b1) ferr_l++;
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rev(logic [W-1:0] w);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = w[W-1-i];
    return r;
  endfunction

  task automatic check_all(string tag);
    logic [W-1:0] hd;
    hd = (q.size() != 0) ? q[0] : last_w;
    check({tag, ".vm"}, 32'(vm), 32'(q.size() != 0));
    check({tag, ".vl"}, 32'(vl), 32'(q.size() != 0));
    check({tag, ".lm"}, 32'(lm), 32'(q.size()));
    check({tag, ".ll"}, 32'(ll), 32'(q.size()));
    check({tag, ".om"}, 32'(om), 32'(ovr));
    check({tag, ".ol"}, 32'(ol), 32'(ovr));
    check({tag, ".dm"}, 32'(dm), 32'(hd));
    check({tag, ".dl"}, 32'(dl), 32'(rev(hd)));
  endtask

  task automatic model_push(logic [W-1:0] w);
    if (q.size() < D) q.push_back(w);
    else ovr = 1'b1;
  endtask

  task automatic send_bit(logic f, logic r);
    SCLK = 1'b0; FSS = f; RXD = r;
    tick(2);
    SCLK = 1'b1;
    tick(2);
  endtask

  task automatic idle(int n);
    SCLK = 1'b0; FSS = 1'b0; RXD = 1'b0;
    tick(n);
  endtask

  task automatic send_bits(logic [W-1:0] w, bit first, int nb,
                           logic lastf);
    if (first) send_bit(1'b1, 1'($urandom));
    for (int i = 0; i < nb; i++)
      send_bit((i == W - 1) ? lastf : 1'b0, w[W-1-i]);
  endtask

  task automatic send_frame(logic [W-1:0] w, bit first, logic lastf);
    send_bits(w, first, W, lastf);
    if (ENABLE) model_push(w);
  endtask

  task automatic pop_one(string tag);
    check_all(tag);
    RDY = 1'b1;
    tick();
    RDY = 1'b0;
    if (q.size() != 0) last_w = q.pop_front();
  endtask

  task automatic ovr_clear();
    OCLR = 1'b1;
    tick();
    OCLR = 1'b0;
    ovr = 1'b0;
  endtask

  initial begin
    logic [W-1:0] w;
    CLEAR = 1'b1; ENABLE = 1'b1; SCLK = 1'b0; FSS = 1'b0;
    RXD = 1'b0; RDY = 1'b0; OCLR = 1'b0;
    last_w = '0; ovr = 1'b0;
    tick(3);
    check_all("rst");
    check("rst.fm", 32'(fm), 32'd0);
    check("rst.fl", 32'(fl), 32'd0);
    CLEAR = 1'b0;
    tick(2);

    // B2 frame, last bit driven by hand to time the push
    w = 8'hB2;
    send_bits(w, 1, W - 1, 1'b0);
    SCLK = 1'b0; FSS = 1'b0; RXD = w[0];
    tick(2);
    SCLK = 1'b1;
    tick(2);
    check("lat.k1", 32'(vm), 32'd0);
    tick();
    check("lat.k2", 32'(vm), 32'd1);
    check("lat.k2l", 32'(vl), 32'd1);
    model_push(w);
    check("b2.m", 32'(dm), 32'hB2);
    check("b2.l", 32'(dl), 32'h4D);
    idle(3);
    check_all("b2");
    pop_one("b2.pop");
    check_all("b2.empty");

    // three back-to-back frames
    send_frame(8'h01, 1, 1'b1);
    send_frame(8'h80, 0, 1'b1);
    send_frame(8'hFF, 0, 1'b0);
    idle(4);
    check_all("b2b");
    pop_one("b2b.p0");
    pop_one("b2b.p1");
    pop_one("b2b.p2");
    check_all("b2b.empty");

    // early frame sync on bit 4 aborts the frame
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    ferr_exp++;
    send_frame(8'h5A, 0, 1'b0);
    idle(4);
    check("abort.fm", 32'(ferr_m), 32'(ferr_exp));
    check("abort.fl", 32'(ferr_l), 32'(ferr_exp));
    check_all("abort");
    pop_one("abort.pop");

    // fill past depth
    for (int i = 0; i < D + 1; i++) begin
      send_frame(8'h10 + 8'(i), 1, 1'b0);
      idle(2);
    end
    idle(2);
    check_all("full");
    ovr_clear();
    check_all("oclr");

    // tenth frame pushed in the same cycle as a pop
    w = 8'hC7;
    send_bits(w, 1, W - 1, 1'b0);
    SCLK = 1'b0; FSS = 1'b0; RXD = w[0];
    tick(2);
    SCLK = 1'b1;
    tick(2);
    RDY = 1'b1;
    tick();
    RDY = 1'b0;
    last_w = q.pop_front();
    q.push_back(w);
    idle(3);
    check_all("pushpop");
    while (q.size() != 0) pop_one("drain");
    check_all("drain.empty");

    // clear mid-frame with two words stored
    send_frame(8'hA1, 1, 1'b0);
    send_frame(8'h5E, 1, 1'b0);
    send_bits(8'hE7, 1, 5, 1'b0);
    SCLK = 1'b0;
    CLEAR = 1'b1;
    tick();
    q.delete();
    last_w = '0;
    ovr = 1'b0;
    check_all("clr");
    CLEAR = 1'b0;
    tick();
    send_frame(8'h3C, 1, 1'b0);
    idle(4);
    check_all("clr.3c");

    // disabled receiver drops frames, FIFO untouched
    ENABLE = 1'b0;
    send_frame(8'h99, 1, 1'b0);
    idle(4);
    ENABLE = 1'b1;
    check_all("dis");
    pop_one("dis.pop");
    check_all("dis.empty");

    // random frames and pops
    for (int i = 0; i < 24; i++) begin
      send_frame(8'($urandom), 1, 1'b0);
      idle(4);
      check_all("rnd");
      repeat ($urandom_range(0, 1)) pop_one("rnd.pop");
      if ($urandom_range(0, 5) == 0) ovr_clear();
    end
    while (q.size() != 0) pop_one("rnd.drain");
    check_all("rnd.end");
    check("ferr.m", 32'(ferr_m), 32'(ferr_exp));
    check("ferr.l", 32'(ferr_l), 32'(ferr_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
